// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core: cause indices, opcodes/functs, and
// the decode helpers used by the interrupt unit.
package mips_pkg;
    localparam int NCAUSE = 23;

    localparam int C_RESET  = 0;
    localparam int C_ILL    = 1;
    localparam int C_MISAF  = 2;
    localparam int C_MISALS = 3;
    localparam int C_PFF    = 4;
    localparam int C_PFLS   = 5;
    localparam int C_SYSC   = 6;
    localparam int C_OVF    = 7;
    localparam int C_EXT0   = 8;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_COP     = 6'h10;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ERET    = 6'h18;

    // Causes whose handler must re-execute the faulting instruction.
    localparam logic [NCAUSE-1:0] REPEAT_MASK = 23'h3F;

    typedef struct packed {
        logic [31:0] sr;
        logic [31:0] esr;
        logic [31:0] eca;
        logic [31:0] epc;
        logic [31:0] edata;
        logic        mode;
    } spr_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {6'h00, [6'h02:6'h10], 6'h20, 6'h21, 6'h23, 6'h24,
                          6'h25, 6'h28, 6'h29, 6'h2B};
    endfunction
endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder over the masked cause vector.
module int_prio_enc #(
    parameter int W  = 23,
    parameter int LW = $clog2(W)
) (
    input  logic [W-1:0]  req,
    output logic [LW-1:0] idx,
    output logic          any
);
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--)
            if (req[i]) idx = LW'(i);
    end

    assign any = |req;
endmodule

// File: rtl/main_interrupt.sv
// Precise interrupt/exception unit: merges external and decoded causes,
// masks them, and computes next SR/ESR/ECA/EPC/EDATA/mode.
module main_interrupt
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic [22:0] ca,
    input  logic [31:0] sr,
    input  logic [31:0] esr,
    input  logic [31:0] pc,
    input  logic        e,
    input  logic        eret,
    input  logic        rpt,
    input  logic [31:0] next_pc,
    input  logic        mode,
    output logic [31:0] sr_out,
    output logic [31:0] esr_out,
    output logic [31:0] eca_out,
    output logic [31:0] epc_out,
    output logic [31:0] edata_out,
    output logic [31:0] pto,
    output logic [31:0] ptl,
    output logic        mode_out,
    output logic        jisr
);
    logic [5:0]        op, fn;
    logic [NCAUSE-1:0] icause, mca;
    logic [4:0]        il;
    logic              any, eret_all, emode;
    spr_t              r;
    logic              unused_instr;

    assign op = instruction[31:26];
    assign fn = instruction[5:0];
    assign unused_instr = ^instruction[25:16];

    always_comb begin
        icause           = '0;
        icause[C_ILL]    = !op_legal(op) || (op == OP_COP && mode);
        icause[C_MISAF]  = e && (pc[1:0] != 2'b00);
        icause[C_MISALS] = ((op == OP_LW || op == OP_SW) && instruction[1:0] != 2'b00) ||
                           ((op == OP_LH || op == OP_LHU || op == OP_SH) && instruction[0]);
        icause[C_SYSC]   = (op == OP_SPECIAL) && (fn == FN_SYSCALL);
    end

    // Causes 0..6 are non-maskable; the rest are gated by the matching SR bit.
    assign mca = (ca | icause) & {sr[NCAUSE-1:C_OVF], 7'h7F};

    int_prio_enc #(.W(NCAUSE), .LW(5)) u_enc (
        .req (mca),
        .idx (il),
        .any (any)
    );

    assign jisr     = rst | any;
    assign eret_all = eret | (op == OP_COP && fn == FN_ERET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r       <= '0;
            r.eca   <= 32'd1;
            emode   <= 1'b0;
        end else if (any) begin
            r.esr   <= sr;
            r.sr    <= '0;
            r.eca   <= {9'b0, mca};
            r.epc   <= (REPEAT_MASK[il] || rpt) ? pc : next_pc;
            r.edata <= (il == 5'(C_MISALS) || il == 5'(C_PFLS)) ?
                       {{16{instruction[15]}}, instruction[15:0]} : 32'd0;
            r.mode  <= 1'b0;
            emode   <= mode;
        end else if (eret_all) begin
            r.sr    <= esr;
            r.mode  <= emode;
        end else begin
            r.sr    <= sr;
            r.esr   <= esr;
            r.mode  <= mode;
        end
    end

    // Page-table registers are reserved; no write path exists yet.
    assign pto       = '0;
    assign ptl       = '0;
    assign sr_out    = r.sr;
    assign esr_out   = r.esr;
    assign eca_out   = r.eca;
    assign epc_out   = r.epc;
    assign edata_out = r.edata;
    assign mode_out  = r.mode;
endmodule

// File: tb/tb_main_interrupt.sv
// Scoreboard bench for main_interrupt: driver pushes model expectations,
// monitor pops and compares after each rising edge.
module tb_main_interrupt;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instruction, sr, esr, pc, next_pc;
    logic [22:0] ca;
    logic        e, eret, rpt, mode;
    logic [31:0] sr_out, esr_out, eca_out, epc_out, edata_out, pto, ptl;
    logic        mode_out, jisr;

    main_interrupt dut (
        .clk(clk), .rst(rst), .instruction(instruction), .ca(ca), .sr(sr),
        .esr(esr), .pc(pc), .e(e), .eret(eret), .rpt(rpt), .next_pc(next_pc),
        .mode(mode), .sr_out(sr_out), .esr_out(esr_out), .eca_out(eca_out),
        .epc_out(epc_out), .edata_out(edata_out), .pto(pto), .ptl(ptl),
        .mode_out(mode_out), .jisr(jisr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sr, esr, eca, epc, edata;
        logic        mode;
    } exp_t;

    exp_t q[$];
    exp_t ms;
    logic memode;
    int   checks = 0;
    int   errors = 0;
    int   legal_ops[] = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                          8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10,
                          8'h20, 8'h21, 8'h23, 8'h24, 8'h25, 8'h28, 8'h29, 8'h2B};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: applies the cause/priority rules directly to the inputs.
    task automatic drive(input logic r, input logic [31:0] ins, input logic [22:0] c,
                         input logic [31:0] s, input logic [31:0] es, input logic [31:0] p,
                         input logic ee, input logic er, input logic rp,
                         input logic [31:0] np, input logic md, input string nm);
        int op, fn, il;
        bit legal, exp_j;
        logic [22:0] cause, mca;
        logic signed [15:0] imm;
        @(negedge clk);
        rst = r; instruction = ins; ca = c; sr = s; esr = es; pc = p;
        e = ee; eret = er; rpt = rp; next_pc = np; mode = md;
        #1;
        if (r) begin
            ms = '{sr: 0, esr: 0, eca: 1, epc: 0, edata: 0, mode: 0};
            memode = 0;
            exp_j = 1;
        end else begin
            op = int'(ins[31:26]);
            fn = int'(ins[5:0]);
            legal = 0;
            foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1;
            cause = c;
            if (!legal || (op == 'h10 && md)) cause[1] = 1;
            if (ee && p % 4 != 0) cause[2] = 1;
            if ((op == 'h23 || op == 'h2B) && ins % 4 != 0) cause[3] = 1;
            if ((op == 'h21 || op == 'h25 || op == 'h29) && ins % 2 != 0) cause[3] = 1;
            if (op == 0 && fn == 'h0C) cause[6] = 1;
            mca = 0;
            for (int k = 0; k < 23; k++) mca[k] = cause[k] && (k < 7 || s[k]);
            il = -1;
            for (int k = 22; k >= 0; k--) if (mca[k]) il = k;
            exp_j = (mca != 0);
            if (exp_j) begin
                imm = ins[15:0];
                ms.esr   = s;
                ms.sr    = 0;
                ms.eca   = 32'(mca);
                ms.epc   = (il <= 5 || rp) ? p : np;
                ms.edata = (il == 3 || il == 5) ? 32'(imm) : 32'd0;
                ms.mode  = 0;
                memode   = md;
            end else if (er || (op == 'h10 && fn == 'h18)) begin
                ms.sr   = es;
                ms.mode = memode;
            end else begin
                ms.sr   = s;
                ms.esr  = es;
                ms.mode = md;
            end
        end
        chk({nm, ".jisr"}, 32'(jisr), 32'(exp_j));
        q.push_back(ms);
    endtask

    always @(posedge clk) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("sr_out", sr_out, x.sr);
            chk("esr_out", esr_out, x.esr);
            chk("eca_out", eca_out, x.eca);
            chk("epc_out", epc_out, x.epc);
            chk("edata_out", edata_out, x.edata);
            chk("mode_out", 32'(mode_out), 32'(x.mode));
            chk("pto", pto, 32'd0);
            chk("ptl", ptl, 32'd0);
        end
    end

    initial begin
        logic [31:0] rins, rsr, rpc, r26;
        logic [22:0] rca;
        int ops[] = '{6'h00, 6'h01, 6'h02, 6'h08, 6'h10, 6'h20, 6'h21, 6'h23,
                      6'h25, 6'h29, 6'h2B, 6'h3F, 6'h24};
        rst = 1; instruction = 0; ca = 0; sr = 0; esr = 0; pc = 0;
        e = 0; eret = 0; rpt = 0; next_pc = 0; mode = 0;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset0");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset1");
        drive(0, 0, 0, 0, 0, 32'h100, 0, 0, 0, 32'h104, 0, "clean");
        drive(0, 32'h40000000, 0, 0, 32'h5, 32'h200, 0, 0, 0, 32'h204, 1, "ill_user");
        drive(0, 32'h40000000, 0, 32'h0000F00F, 0, 32'h208, 0, 0, 0, 32'h20C, 1, "ill_esr");
        drive(0, 32'h04000000, 0, 0, 0, 32'h210, 0, 0, 0, 32'h214, 0, "ill_op01");
        drive(0, 0, 0, 0, 0, 32'h1, 1, 0, 0, 32'h5, 0, "misaf");
        drive(0, 0, 0, 0, 0, 32'h1, 0, 0, 0, 32'h5, 0, "misaf_noe");
        drive(0, 32'h8C000001, 0, 0, 0, 32'h300, 0, 0, 0, 32'h304, 0, "lw_mis");
        drive(0, 32'hAC000001, 0, 0, 0, 32'h304, 0, 0, 0, 32'h308, 0, "sw_mis");
        drive(0, 32'h84008001, 0, 0, 0, 32'h308, 0, 0, 0, 32'h30C, 0, "lh_mis");
        drive(0, 32'h0000000C, 0, 0, 0, 32'h400, 0, 0, 0, 32'h10, 0, "sysc");
        drive(0, 32'h0000000C, 0, 0, 0, 32'h404, 0, 0, 1, 32'h10, 0, "sysc_rpt");
        drive(0, 0, 23'h200, 0, 0, 32'h500, 0, 0, 0, 32'h504, 1, "ext9_masked");
        drive(0, 0, 23'h200, 32'h200, 0, 32'h504, 0, 0, 0, 32'h508, 1, "ext9");
        drive(0, 32'h40000018, 0, 0, 32'hFFFFFFFF, 32'h600, 0, 0, 0, 32'h604, 0, "eret");
        drive(0, 0, 23'h80, 32'h80, 32'h3, 32'h700, 0, 1, 0, 32'h704, 0, "int_vs_eret");
        drive(0, 0, 0, 0, 32'h77, 32'h704, 0, 1, 0, 32'h708, 0, "ext_eret");
        drive(0, 32'h8C000001, 23'h7FFFFF, 32'hFFFFFFFF, 0, 32'h800, 1, 0, 0, 32'h804, 1, "all_causes");
        drive(0, 0, 23'h7FFF80, 0, 0, 32'h900, 0, 0, 0, 32'h904, 0, "sr_zero");
        drive(1, 32'h0000000C, 0, 0, 0, 32'hA00, 0, 0, 0, 32'hA04, 1, "mid_reset");
        drive(0, 0, 0, 32'h1234, 32'h99, 32'hA04, 0, 0, 0, 32'hA08, 1, "post_reset");

        for (int n = 0; n < 400; n++) begin
            rins = $urandom();
            r26  = rins;
            rins = {6'(ops[$urandom_range(0, ops.size() - 1)]), r26[25:0]};
            if ($urandom_range(0, 3) == 0) rins[5:0] = ($urandom_range(0, 1) != 0) ? 6'h0C : 6'h18;
            rca = 0;
            if ($urandom_range(0, 3) == 0) rca = 23'($urandom()) & 23'h7FFF80;
            if ($urandom_range(0, 15) == 0) rca = 23'(1 << $urandom_range(0, 22));
            rsr = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom();
            rpc = $urandom();
            drive($urandom_range(0, 60) == 0, rins, rca, rsr, $urandom(), rpc,
                  1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, $urandom(), 1'($urandom_range(0, 1)), "rand");
        end

        @(negedge clk);
        rst = 0; ca = 0; instruction = 0; e = 0; eret = 0;
        @(posedge clk);
        #2;
        chk("drain", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
